// File: rtl/i2c_slave_responder.sv
// I2C target: synchronizes SCL/SDA, decodes START/STOP, matches a 7-bit address and
// receives/transmits bytes with ACK handling. SDA is only ever pulled low or released.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i2c_core_clock,
    input  logic       preset,
    input  logic       scl_io,
    inout  wire        sda_io,
    input  logic [7:0] tx_data_i,
    input  logic       nack_i,
    output logic       tx_load_o,
    output logic [7:0] data_slave_read,
    output logic       data_slave_read_valid,
    output logic       start,
    output logic       stop,
    output logic       rw_o,
    output logic       busy_o,
    output logic [7:0] byte_cnt_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic       phase_q, phase_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rd_q, rd_d;
    logic       rd_vld_q, rd_vld_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic       tx_load_q, tx_load_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The synchronizer keeps tracking the bus during reset so no false edge appears on release.
    always_ff @(posedge i2c_core_clock) begin
        scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_io};
        sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_io};
        scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
        sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_ff @(posedge i2c_core_clock) begin
        if (preset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            phase_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            rd_q       <= '0;
            rd_vld_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            byte_cnt_q <= '0;
            tx_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            rd_q       <= rd_d;
            rd_vld_q   <= rd_vld_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            byte_cnt_q <= byte_cnt_d;
            tx_load_q  <= tx_load_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        if (start_det) begin
            state_d = S_ADDR;
        end else if (stop_det) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:     state_d = S_IDLE;
                S_ADDR:     if (scl_rise && cnt_q == 4'd7)
                                state_d = (sh_q[6:0] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK: if (scl_fall && phase_q) state_d = rw_q ? S_TX : S_RX;
                S_RX:       if (scl_rise && cnt_q == 4'd7) state_d = S_RX_ACK;
                // sda_oe_q still holds the ACK/NACK decision made at the first fall
                S_RX_ACK:   if (scl_fall && phase_q) state_d = sda_oe_q ? S_RX : S_IGNORE;
                S_TX:       if (scl_fall && cnt_q == 4'd8) state_d = S_TX_ACK;
                S_TX_ACK:   if (scl_rise && sda_s) state_d = S_IGNORE;
                            else if (scl_fall && phase_q) state_d = S_TX;
                S_IGNORE:   state_d = S_IGNORE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin : output_next
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        rd_d       = rd_q;
        rd_vld_d   = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        rw_d       = rw_q;
        busy_d     = busy_q;
        byte_cnt_d = byte_cnt_q;
        tx_load_d  = 1'b0;
        if (start_det) begin
            start_d    = 1'b1;
            cnt_d      = '0;
            phase_d    = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            byte_cnt_d = '0;
        end else if (stop_det) begin
            stop_d   = 1'b1;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    sh_d  = {sh_q[6:0], sda_s};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        phase_d = 1'b0;
                        if (sh_q[6:0] == SLAVE_ADDR) begin
                            rw_d   = sda_s;
                            busy_d = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        cnt_d    = '0;
                        sda_oe_d = 1'b0;
                        if (rw_q) begin
                            sh_d      = tx_data_i;
                            sda_oe_d  = ~tx_data_i[7];
                            tx_load_d = 1'b1;
                            cnt_d     = 4'd1;
                        end
                    end
                end
                S_RX: if (scl_rise) begin
                    sh_d  = {sh_q[6:0], sda_s};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rd_d       = {sh_q[6:0], sda_s};
                        rd_vld_d   = 1'b1;
                        byte_cnt_d = sat_inc(byte_cnt_q);
                        cnt_d      = '0;
                        phase_d    = 1'b0;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = ~nack_i;
                        phase_d  = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        cnt_d    = '0;
                        if (!sda_oe_q) busy_d = 1'b0;
                    end
                end
                // sh_q[7] is always the bit currently on the bus
                S_TX: if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                    end else begin
                        sda_oe_d = ~sh_q[6];
                        sh_d     = {sh_q[6:0], 1'b0};
                        cnt_d    = cnt_q + 4'd1;
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        byte_cnt_d = sat_inc(byte_cnt_q);
                        if (sda_s) busy_d = 1'b0;
                        else       phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        sh_d      = tx_data_i;
                        sda_oe_d  = ~tx_data_i[7];
                        tx_load_d = 1'b1;
                        cnt_d     = 4'd1;
                        phase_d   = 1'b0;
                    end
                end
                S_IGNORE: begin
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    assign sda_io                = sda_oe_q ? 1'b0 : 1'bz;
    assign tx_load_o             = tx_load_q;
    assign data_slave_read       = rd_q;
    assign data_slave_read_valid = rd_vld_q;
    assign start                 = start_q;
    assign stop                  = stop_q;
    assign rw_o                  = rw_q;
    assign busy_o                = busy_q;
    assign byte_cnt_o            = byte_cnt_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-banged I2C master plus a scoreboard for received
// bytes and the bytes the target transmits.
module tb_i2c_slave_responder;
    logic       clk = 1'b0;
    logic       preset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       nack_i = 1'b0;
    logic [7:0] tx_data_i = 8'hFF;
    wire        sda;
    logic       tx_load_o, data_slave_read_valid, start, stop, rw_o, busy_o;
    logic [7:0] data_slave_read, byte_cnt_o;

    int n_checks = 0, n_fail = 0;
    int n_start = 0, n_stop = 0, n_load = 0, n_valid = 0, n_drive = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] tx_mem[8];
    int tx_wr = 0, tx_rd = 0;

    always #5 clk = ~clk;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    i2c_slave_responder #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .i2c_core_clock       (clk),
        .preset               (preset),
        .scl_io               (scl),
        .sda_io               (sda),
        .tx_data_i            (tx_data_i),
        .nack_i               (nack_i),
        .tx_load_o            (tx_load_o),
        .data_slave_read      (data_slave_read),
        .data_slave_read_valid(data_slave_read_valid),
        .start                (start),
        .stop                 (stop),
        .rw_o                 (rw_o),
        .busy_o               (busy_o),
        .byte_cnt_o           (byte_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counting and scoreboard pops, sampled mid-cycle
    always @(posedge clk) begin
        #3;
        if (start) n_start++;
        if (stop) n_stop++;
        if (tx_load_o) begin
            n_load++;
            tx_rd++;
        end
        if (data_slave_read_valid) begin
            n_valid++;
            if (rx_exp_q.size() == 0) check_eq("rx_unexpected", 32'(rx_exp_q.size()), 32'd1);
            else check_eq("rx_data", 32'(data_slave_read), 32'(rx_exp_q.pop_front()));
        end
        tx_data_i = (tx_rd < tx_wr) ? tx_mem[tx_rd] : 8'hFF;
        if (sda === 1'b0 && m_sda) n_drive++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic hw(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input logic b);
        hw(5); m_sda = b; hw(5); scl = 1'b1; hw(10); scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        hw(5); m_sda = 1'b1; hw(5); scl = 1'b1; hw(5); b = sda; hw(5); scl = 1'b0;
    endtask

    task automatic i2c_start();
        hw(5); m_sda = 1'b1; hw(5); scl = 1'b1; hw(10); m_sda = 1'b0; hw(10); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        hw(5); m_sda = 1'b0; hw(5); scl = 1'b1; hw(10); m_sda = 1'b1; hw(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(v);
        ack = ~v;
        hw(4);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            get_bit(v);
            b[i] = v;
        end
        put_bit(~master_ack);
        hw(4);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         s0, d0, v0, l0;

        hw(5);
        preset = 1'b0;
        hw(2);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_byte_cnt", 32'(byte_cnt_o), 32'd0);
        check_eq("rst_data", 32'(data_slave_read), 32'd0);
        check_eq("rst_pulses", 32'({start, stop, tx_load_o, data_slave_read_valid, rw_o}), 32'd0);
        check_eq("rst_sda", 32'(sda), 32'd1);

        // 1) write two bytes
        v0 = n_valid; s0 = n_stop;
        i2c_start();
        write_byte(8'hA0, ack);
        check_eq("t1_addr_ack", 32'(ack), 32'd1);
        check_eq("t1_busy", 32'(busy_o), 32'd1);
        check_eq("t1_rw", 32'(rw_o), 32'd0);
        rx_exp_q.push_back(8'h3C);
        write_byte(8'h3C, ack);
        check_eq("t1_b1_ack", 32'(ack), 32'd1);
        rx_exp_q.push_back(8'hC3);
        write_byte(8'hC3, ack);
        check_eq("t1_b2_ack", 32'(ack), 32'd1);
        check_eq("t1_byte_cnt", 32'(byte_cnt_o), 32'd2);
        i2c_stop();
        check_eq("t1_valid_cnt", 32'(n_valid - v0), 32'd2);
        check_eq("t1_stop_cnt", 32'(n_stop - s0), 32'd1);
        check_eq("t1_busy_after_stop", 32'(busy_o), 32'd0);

        // 2) wrong address
        d0 = n_drive; v0 = n_valid;
        i2c_start();
        write_byte(8'hA2, ack);
        check_eq("t2_addr_nack", 32'(ack), 32'd0);
        check_eq("t2_busy", 32'(busy_o), 32'd0);
        i2c_stop();
        check_eq("t2_no_drive", 32'(n_drive - d0), 32'd0);
        check_eq("t2_no_valid", 32'(n_valid - v0), 32'd0);

        // 3) read two bytes, master ACK then NACK
        l0 = n_load;
        tx_mem[tx_wr] = 8'h96; tx_wr++; rd_exp_q.push_back(8'h96);
        tx_mem[tx_wr] = 8'h5A; tx_wr++; rd_exp_q.push_back(8'h5A);
        i2c_start();
        write_byte(8'hA1, ack);
        check_eq("t3_addr_ack", 32'(ack), 32'd1);
        check_eq("t3_rw", 32'(rw_o), 32'd1);
        read_byte(1'b1, rb);
        check_eq("t3_rd0", 32'(rb), 32'(rd_exp_q.pop_front()));
        read_byte(1'b0, rb);
        check_eq("t3_rd1", 32'(rb), 32'(rd_exp_q.pop_front()));
        check_eq("t3_load_cnt", 32'(n_load - l0), 32'd2);
        check_eq("t3_busy_after_nack", 32'(busy_o), 32'd0);
        check_eq("t3_sda_released", 32'(sda), 32'd1);
        check_eq("t3_byte_cnt", 32'(byte_cnt_o), 32'd2);
        i2c_stop();

        // 4) write, repeated START, read
        s0 = n_start;
        i2c_start();
        write_byte(8'hA0, ack);
        rx_exp_q.push_back(8'h11);
        write_byte(8'h11, ack);
        check_eq("t4_b_ack", 32'(ack), 32'd1);
        check_eq("t4_byte_cnt1", 32'(byte_cnt_o), 32'd1);
        check_eq("t4_rw0", 32'(rw_o), 32'd0);
        i2c_start();
        check_eq("t4_start_cnt", 32'(n_start - s0), 32'd2);
        check_eq("t4_byte_cnt_clr", 32'(byte_cnt_o), 32'd0);
        tx_mem[tx_wr] = 8'h77; tx_wr++; rd_exp_q.push_back(8'h77);
        write_byte(8'hA1, ack);
        check_eq("t4_raddr_ack", 32'(ack), 32'd1);
        check_eq("t4_rw1", 32'(rw_o), 32'd1);
        read_byte(1'b0, rb);
        check_eq("t4_rd", 32'(rb), 32'(rd_exp_q.pop_front()));
        i2c_stop();

        // 5) target NACKs the second data byte
        v0 = n_valid;
        i2c_start();
        write_byte(8'hA0, ack);
        rx_exp_q.push_back(8'h01);
        write_byte(8'h01, ack);
        check_eq("t5_b1_ack", 32'(ack), 32'd1);
        nack_i = 1'b1;
        rx_exp_q.push_back(8'h02);
        write_byte(8'h02, ack);
        nack_i = 1'b0;
        check_eq("t5_b2_nack", 32'(ack), 32'd0);
        check_eq("t5_busy", 32'(busy_o), 32'd0);
        write_byte(8'h03, ack);
        check_eq("t5_b3_nack", 32'(ack), 32'd0);
        check_eq("t5_valid_cnt", 32'(n_valid - v0), 32'd2);
        check_eq("t5_byte_cnt", 32'(byte_cnt_o), 32'd2);
        i2c_stop();

        // 6) reset while the target drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) put_bit(tx_mem_addr_bit(i));
        hw(5); m_sda = 1'b1; hw(1);
        check_eq("t6_ack_driven", 32'(sda), 32'd0);
        check_eq("t6_rw_before", 32'(rw_o), 32'd1);
        preset = 1'b1;
        hw(1);
        check_eq("t6_sda_released", 32'(sda), 32'd1);
        check_eq("t6_rst_outs", 32'({busy_o, rw_o, start, stop, tx_load_o, data_slave_read_valid}), 32'd0);
        check_eq("t6_rst_data", 32'({data_slave_read, byte_cnt_o}), 32'd0);
        hw(3);
        preset = 1'b0;
        s0 = n_start;
        i2c_start();
        check_eq("t6_start_again", 32'(n_start - s0), 32'd1);
        write_byte(8'hA0, ack);
        check_eq("t6_addr_ack", 32'(ack), 32'd1);
        rx_exp_q.push_back(8'h42);
        write_byte(8'h42, ack);
        check_eq("t6_byte_cnt", 32'(byte_cnt_o), 32'd1);
        i2c_stop();

        hw(10);
        check_eq("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Address byte 0xA1 (0x50, read) used for the reset-during-ACK case
    function automatic logic tx_mem_addr_bit(input int i);
        logic [7:0] a;
        a = 8'hA1;
        return a[i];
    endfunction
endmodule
